bcd_to_binary_seq: RTL and testbench
====================================

// Module: bcd_to_binary_seq
// PURPOSE
//   Parametrised, digit-serial packed-BCD to binary converter with valid/ready handshakes on both sides.
//   Extends the 2-digit combinational converter to DIGITS decimal digits.
//   Processes one digit per clock, most significant first: acc <= acc*10 + digit.
//   Flags any non-decimal nibble (>9) instead of producing a silently wrong result.
//   Sits between decimal front-end logic (keypad, display, BCD counters) and binary datapath logic.
// PARAMETERS
//   DIGITS  4   number of BCD digits in bcd_in (>=1)
//   BIN_W   14  result width; must be >= ceil(log2(10**DIGITS)) (DIGITS=2 -> 7, DIGITS=4 -> 14)
// PORTS
//   clk        in   1          clock, all state updates on rising edge
//   rst        in   1          asynchronous, active-high reset
//   in_valid   in   1          bcd_in is valid
//   in_ready   out  1          converter idle, can accept an input
//   bcd_in     in   4*DIGITS   packed BCD; nibble [4*DIGITS-1 -: 4] is the most significant digit
//   out_valid  out  1          bin_out/err are valid
//   out_ready  in   1          downstream accepts the result
//   bin_out    out  BIN_W      binary value of bcd_in; 0 when err=1
//   err        out  1          at least one nibble of the accepted bcd_in was >9
// BEHAVIOUR
//   Reset
//     - rst=1 (any time, asynchronous) -> state IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, acc=0, digit count=0.
//     - Reset during CONV or DONE discards the conversion; no out_valid pulse follows.
//   FSM states IDLE, CONV, DONE (registered outputs)
//     - IDLE: in_ready=1, out_valid=0.
//       - On in_valid && in_ready: capture bcd_in into a shift register, acc=0, cnt=DIGITS-1.
//       - Also capture err = OR over all nibbles of (nibble>9); then go to CONV.
//     - CONV: in_ready=0. Each cycle: acc <= acc*10 + top nibble, shift the register left 4 bits, cnt <= cnt-1.
//       - The cycle where cnt==0 is the last digit: load bin_out (0 if err), set out_valid=1, go to DONE.
//     - DONE: out_valid=1; bin_out and err held stable until out_valid && out_ready.
//       - On that handshake: out_valid=0, go to IDLE. in_ready returns 1 on the following cycle.
//   Timing
//     - Latency: out_valid rises DIGITS rising edges after the accepting edge.
//     - Throughput: one conversion per DIGITS+2 cycles with out_ready held high.
//   Ignored inputs
//     - in_valid while in_ready=0 is ignored; bcd_in is not sampled.
//     - out_ready while out_valid=0 has no effect.
//   Arithmetic
//     - acc*10 is formed as (acc<<3)+(acc<<1) at BIN_W+4 bits, then truncated to BIN_W.
//     - With BIN_W sized as above, no overflow occurs for legal input.
//     - Illegal nibbles are still accumulated internally, but the result is forced to 0 via err.
//   Boundaries
//     - All-zero input -> bin_out=0, err=0.
//     - All-nines input -> 10**DIGITS-1.
//     - DIGITS=1 -> CONV lasts exactly one cycle.
// TESTING
//   1. DIGITS=4, BIN_W=14: bcd_in=16'h0015 -> out_valid exactly 4 edges after accept; bin_out=15, err=0.
//   2. DIGITS=4: bcd_in=16'h9999 -> bin_out=9999 (14'h270F), err=0.
//      Then 16'h0000 -> bin_out=0, err=0.
//   3. DIGITS=4: bcd_in=16'h12A4 -> err=1, bin_out=0; the next input 16'h1234 -> bin_out=1234, err=0.
//   4. Backpressure: out_ready=0 for 5 cycles after out_valid.
//      -> bin_out/err stable, in_ready=0, a new in_valid is ignored.
//      Raise out_ready -> one handshake, in_ready=1 the next cycle.
//   5. Assert rst 2 cycles into CONV of 16'h4321.
//      -> all outputs at reset values immediately, no out_valid.
//      The following 16'h0042 -> bin_out=42.
//   6. DIGITS=2, BIN_W=7: sweep all 100 legal codes 8'h00..8'h99 -> bin_out = 10*hi+lo.
//      Back-to-back with out_ready=1 -> one result per 4 cycles.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Digit-serial packed-BCD to binary converter, one digit per clock, MSD first.
// Valid/ready handshakes on both sides; non-decimal nibbles flag err and zero the result.
module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    state_e                state_q;
    logic [4*DIGITS-1:0]   shreg_q;
    logic [BIN_W-1:0]      acc_q;
    logic [BIN_W-1:0]      bin_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  bad_q;
    logic                  err_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [BIN_W+3:0]      acc_ext;
    logic [BIN_W+3:0]      acc_mul;
    logic [BIN_W-1:0]      acc_d;
    logic                  bad_d;

    // acc*10 + digit, built from shifts at 4 bits of headroom
    always_comb begin
        acc_ext = {4'b0, acc_q};
        acc_mul = (acc_ext << 3) + (acc_ext << 1)
                + {{BIN_W{1'b0}}, shreg_q[4*DIGITS-1 -: 4]};
        acc_d   = acc_mul[BIN_W-1:0];
    end

    always_comb begin
        bad_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shreg_q    <= bcd_in;
                        acc_q      <= '0;
                        cnt_q      <= CNT_W'(DIGITS - 1);
                        bad_q      <= bad_d;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q << 4;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        bin_q       <= bad_q ? '0 : acc_d;
                        err_q       <= bad_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: directed and random 4-digit conversions,
// plus a back-to-back sweep of all legal 2-digit codes.
module tb_bcd_to_binary_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err;
    logic [15:0] a_bcd;
    logic [13:0] a_bin;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [7:0]  b_bcd;
    logic [6:0]  b_bin;

    bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) u_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .bcd_in    (a_bcd),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .bin_out   (a_bin),
        .err       (a_err)
    );

    bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .bcd_in    (b_bcd),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .bin_out   (b_bin),
        .err       (b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Decimal meaning of a packed BCD word: sum of digit * 10^position
    function automatic void model4(input logic [15:0] code,
                                   output int value, output bit bad);
        int p;
        int d;
        value = 0;
        bad   = 1'b0;
        p     = 1;
        for (int k = 0; k < 4; k++) begin
            d = int'(code[4*k +: 4]);
            if (d > 9) bad = 1'b1;
            value = value + d * p;
            p = p * 10;
        end
    endfunction

    task automatic send4(input logic [15:0] code);
        int n;
        n = 0;
        while (!a_in_ready && n < 50) begin
            tick();
            n++;
        end
        check("a_ready_wait", a_in_ready, 1);
        a_bcd      = code;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("a_accept_busy", a_in_ready, 0);
    endtask

    task automatic wait_out4(output int n);
        n = 0;
        while (!a_out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic conv4(input logic [15:0] code, input string tag);
        int v;
        bit e;
        int n;
        model4(code, v, e);
        send4(code);
        wait_out4(n);
        check({tag, "_lat"}, n, 4);
        check({tag, "_bin"}, a_bin, e ? 0 : v);
        check({tag, "_err"}, a_err, e);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check({tag, "_ovclr"}, a_out_valid, 0);
        check({tag, "_irdy"}, a_in_ready, 1);
    endtask

    initial begin
        logic [15:0] code;
        logic [13:0] held_bin;
        logic        held_err;
        int          n;
        int          last_acc;
        bit          seen;

        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_bcd       = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_bcd       = '0;
        repeat (3) tick();
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_bin", a_bin, 0);
        check("rst_err", a_err, 0);
        rst = 1'b0;
        tick();

        conv4(16'h0015, "d0015");
        conv4(16'h9999, "d9999");
        conv4(16'h0000, "d0000");
        conv4(16'h12A4, "d12A4");
        conv4(16'h1234, "d1234");

        // Backpressure: result held, new input ignored
        send4(16'h0567);
        wait_out4(n);
        check("bp_lat", n, 4);
        held_bin = a_bin;
        held_err = a_err;
        check("bp_bin", held_bin, 567);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_bcd      = 16'h9999;
            tick();
            check("bp_valid_hold", a_out_valid, 1);
            check("bp_bin_hold", a_bin, held_bin);
            check("bp_err_hold", a_err, held_err);
            check("bp_in_ready", a_in_ready, 0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("bp_ovclr", a_out_valid, 0);
        check("bp_irdy", a_in_ready, 1);
        tick();
        check("bp_no_extra", a_out_valid, 0);

        // Reset in the middle of a conversion
        send4(16'h4321);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mrst_in_ready", a_in_ready, 1);
        check("mrst_out_valid", a_out_valid, 0);
        check("mrst_bin", a_bin, 0);
        check("mrst_err", a_err, 0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_out_valid) seen = 1'b1;
        end
        check("mrst_no_ov", seen, 0);
        conv4(16'h0042, "d0042");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) begin
                    code[4*k +: 4] = 4'($urandom_range(0, 9));
                end
            end else begin
                code = 16'($urandom);
            end
            conv4(code, "rand");
        end

        // 2-digit sweep, back to back with out_ready held
        b_out_ready = 1'b1;
        last_acc    = 0;
        for (int i = 0; i < 100; i++) begin
            n = 0;
            while (!b_in_ready && n < 20) begin
                tick();
                n++;
            end
            check("sw_ready_wait", b_in_ready, 1);
            b_bcd      = 8'((i / 10) * 16 + (i % 10));
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
            if (i > 0) check("sw_period", cyc - last_acc, 4);
            last_acc = cyc;
            n = 0;
            while (!b_out_valid && n < 20) begin
                tick();
                n++;
            end
            check("sw_lat", n, 2);
            check("sw_bin", b_bin, i);
            check("sw_err", b_err, 0);
            tick();
        end
        b_out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
